rf_arbiter: RTL

- Shares one reg8x16 register file (8 x 16-bit, single Address port, WrEn/RdEn, RdData registered) between NREQ requesters.
- Requesters use a req/ack handshake. The arbiter grants round-robin and drives the register file port with registered controls.
- Returns read data with ack.
- Sits between the register file and its client blocks (host interface, datapath sequencer).

---
 rtl/rf_arb_pkg.sv | 15 +
 rtl/rf_arbiter_if.sv | 30 +++
 rtl/rf_arbiter_rr_picker.sv | 31 +++
 rtl/rf_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and limits for the register-file arbiter.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_e;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;
    localparam int NREQ_MIN   = 2;
    localparam int NREQ_MAX   = 4;

endpackage

// File: rtl/rf_arbiter_if.sv
// Requester handshake plus register-file port; slave = arbiter, master = clients/regfile.
interface rf_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [NREQ-1:0]        Req;
    logic [NREQ-1:0]        We;
    logic [NREQ*ADDR_W-1:0] ReqAddr;
    logic [NREQ*DATA_W-1:0] ReqWrData;
    logic [NREQ-1:0]        Ack;
    logic [DATA_W-1:0]      RdDataOut;
    logic [NREQ-1:0]        Grant;
    logic                   Busy;
    logic                   WrEn;
    logic                   RdEn;
    logic [ADDR_W-1:0]      Address;
    logic [DATA_W-1:0]      WrData;
    logic [DATA_W-1:0]      RdData;

    modport slave (
        input  Req, We, ReqAddr, ReqWrData, RdData,
        output Ack, RdDataOut, Grant, Busy, WrEn, RdEn, Address, WrData
    );

    modport master (
        output Req, We, ReqAddr, ReqWrData, RdData,
        input  Ack, RdDataOut, Grant, Busy, WrEn, RdEn, Address, WrData
    );
endinterface

// File: rtl/rf_arbiter_rr_picker.sv
// Combinational round-robin pick: search from ptr+1 upward, wrapping, skipping excluded lanes.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic [NREQ-1:0] excl,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            found
);
    logic [NREQ-1:0] cand;
    int              idx;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        cand    = req & ~excl;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && cand[idx]) begin
                found    = 1'b1;
                win[idx] = 1'b1;
                win_idx  = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/rf_arbiter.sv
// Round-robin arbiter sharing one 8x16 register file; IDLE -> ISSUE -> RESP, RESP can chain into ISSUE.
module rf_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic         CLK,
    input logic         RST,
    rf_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]     widx_q, widx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              is_wr_q, is_wr_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [IW-1:0]     pick_ptr;
    logic [NREQ-1:0]   pick_excl;
    logic [NREQ-1:0]   win;
    logic [IW-1:0]     win_idx;
    logic              found;

    // In RESP the pointer is effectively the current winner, and the winner's own Req is masked
    assign pick_ptr  = (state_q == RESP) ? widx_q  : ptr_q;
    assign pick_excl = (state_q == RESP) ? grant_q : '0;

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req     (bus.Req),
        .ptr     (pick_ptr),
        .excl    (pick_excl),
        .win     (win),
        .win_idx (win_idx),
        .found   (found)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        widx_d  = widx_q;
        ptr_d   = ptr_q;
        is_wr_d = is_wr_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE:    if (!found) begin
                         grant_d = '0;
                         is_wr_d = 1'b0;
                         addr_d  = '0;
                         wdata_d = '0;
                     end
            ISSUE:   state_d = RESP;
            RESP:    begin
                         ptr_d = widx_q;
                         if (!found) begin
                             state_d = IDLE;
                             grant_d = '0;
                             is_wr_d = 1'b0;
                             addr_d  = '0;
                             wdata_d = '0;
                         end
                     end
            default: state_d = IDLE;
        endcase

        if (found && (state_q == IDLE || state_q == RESP)) begin
            state_d = ISSUE;
            grant_d = win;
            widx_d  = win_idx;
            is_wr_d = bus.We[win_idx];
            wr_en_d = bus.We[win_idx];
            rd_en_d = ~bus.We[win_idx];
            addr_d  = bus.ReqAddr[int'(win_idx)*ADDR_W +: ADDR_W];
            wdata_d = bus.ReqWrData[int'(win_idx)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            widx_q  <= '0;
            ptr_q   <= IW'(NREQ-1);
            is_wr_q <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            widx_q  <= widx_d;
            ptr_q   <= ptr_d;
            is_wr_q <= is_wr_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.Ack       = (state_q == RESP) ? grant_q : '0;
    assign bus.RdDataOut = (state_q == RESP && !is_wr_q) ? bus.RdData : '0;
    assign bus.Grant     = grant_q;
    assign bus.Busy      = (state_q != IDLE);
    assign bus.WrEn      = wr_en_q;
    assign bus.RdEn      = rd_en_q;
    assign bus.Address   = addr_q;
    assign bus.WrData    = wdata_q;
endmodule
